// File: rtl/count_pkg.sv
// Shared encodings for the count sequencing controller.
//   state_e  : FSM state codes, also driven on the state output pins
//   SEL_*    : one-hot digit select codes for the time-shared 7-segment decoder
package count_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [1:0] SEL_TENS = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b01;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   level : debounced button level
//   rise  : high for the single cycle in which level first reads 1
// History resets to 1 so a button held through reset is not seen as a press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_q, prev_d;

  assign prev_d = level;
  assign rise   = level & ~prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a 0..MAX_COUNT display counter.
//   clk, rst      : clock, asynchronous active-low reset
//   btn_pause     : debounced level, rising edge toggles run/pause (starts from IDLE)
//   btn_clear     : debounced level, rising edge returns to IDLE with count 0
//   count         : current binary count
//   count_tick    : 1-cycle pulse with the cycle in which an increment/wrap is visible
//   wrap          : 1-cycle pulse with count_tick when count went MAX_COUNT -> 0
//   state         : 00 IDLE, 01 RUN, 10 PAUSE
//   digit_sel     : 10 tens, 01 ones; toggles every SCAN_DIV cycles
//   digit_val     : BCD value of the selected digit, registered with digit_sel
module count_seq_ctrl
  import count_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned MAX_COUNT = 19,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_pause,
  input  logic             btn_clear,
  output logic [CNT_W-1:0] count,
  output logic             count_tick,
  output logic             wrap,
  output logic [1:0]       state,
  output logic [1:0]       digit_sel,
  output logic [3:0]       digit_val
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Tens/ones split for 0..99 by a fixed chain of subtract-10 steps.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  logic pause_rise, clear_rise;

  btn_edge u_pause_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_pause),
    .rise  (pause_rise)
  );

  btn_edge u_clear_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_clear),
    .rise  (clear_rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PrescW-1:0]  presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic [ScanW-1:0]   scan_q, scan_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         dval_q, dval_d;
  logic [7:0]         bcd;

  // Sequencing: clear wins over pause; any press in a cycle drops that cycle's tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear_rise) begin
      state_d = ST_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (pause_rise) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RUN;
          presc_d = '0;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (presc_q == PrescW'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (count_q == CNT_W'(MAX_COUNT)) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end else begin
            presc_d = presc_q + PrescW'(1);
          end
        end
        // Prescaler holds so a resume finishes the interrupted interval.
        ST_PAUSE: presc_d = presc_q;
        ST_IDLE:  presc_d = '0;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Display scan runs in every state; digit value follows the select it is paired with.
  always_comb begin
    sel_d  = sel_q;
    scan_d = scan_q + ScanW'(1);
    if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      sel_d  = (sel_q == SEL_TENS) ? SEL_ONES : SEL_TENS;
    end
    bcd    = bcd_split(7'(count_q));
    dval_d = (sel_d == SEL_TENS) ? bcd[7:4] : bcd[3:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      sel_q   <= SEL_ONES;
      dval_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      dval_q  <= dval_d;
    end
  end

  assign count      = count_q;
  assign count_tick = tick_q;
  assign wrap       = wrap_q;
  assign state      = state_q;
  assign digit_sel  = sel_q;
  assign digit_val  = dval_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with TICK_DIV=4, SCAN_DIV=2, MAX_COUNT=19.
// Stimulus pushes the expected (cycle, count, wrap) of every increment; a monitor pops
// and compares each time count_tick is seen, and flags any tick nobody expected.
module tb_count_seq_ctrl;

  localparam int unsigned CntW = 7;

  logic            clk;
  logic            rst;
  logic            btn_pause;
  logic            btn_clear;
  logic [CntW-1:0] count;
  logic            count_tick;
  logic            wrap;
  logic [1:0]      state;
  logic [1:0]      digit_sel;
  logic [3:0]      digit_val;

  count_seq_ctrl #(
    .TICK_DIV  (4),
    .SCAN_DIV  (2),
    .MAX_COUNT (19),
    .CNT_W     (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pause  (btn_pause),
    .btn_clear  (btn_clear),
    .count      (count),
    .count_tick (count_tick),
    .wrap       (wrap),
    .state      (state),
    .digit_sel  (digit_sel),
    .digit_val  (digit_val)
  );

  typedef struct {
    int cyc;
    int cnt;
    int wr;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every visible increment must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (wrap && !count_tick) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_without_tick at cycle %0d", cyc);
      end
      if (count_tick) begin
        if (q_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: count=%0d wrap=%0d at cycle %0d, none expected",
                   count, wrap, cyc);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("tick_count", int'(count), e.cnt);
          check("tick_wrap", int'(wrap), e.wr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, t, r, q, s, run, prev_sel;
    logic [1:0] sel_s;

    rst       = 1'b0;
    btn_pause = 1'b1;   // held through reset: must not register as a press
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_count", int'(count), 0);
    check("rst_tick", int'(count_tick), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_sel", int'(digit_sel), 1);
    check("rst_dval", int'(digit_val), 0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check("held_state", int'(state), 0);
    check("held_count", int'(count), 0);
    btn_pause = 1'b0;
    repeat (3) @(negedge clk);

    // Start from IDLE and run through the wrap plus two more increments.
    p = cyc;
    btn_pause = 1'b1;
    for (int n = 0; n < 22; n++) q_exp.push_back('{p + 5 + 4 * n, (n + 1) % 20, (n == 19) ? 1 : 0});
    @(negedge clk);
    btn_pause = 1'b0;
    check("start_state", int'(state), 1);
    check("start_count", int'(count), 0);
    wait_until(p + 21);
    check("count_at_20", int'(count), 5);

    // Pause two cycles after the tick that shows count=2, resume ten cycles later.
    t = p + 89;
    wait_until(t + 2);
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    check("pause_state", int'(state), 2);
    wait_until(t + 12);
    check("paused_state", int'(state), 2);
    check("paused_count", int'(count), 2);
    r = cyc;
    btn_pause = 1'b1;
    for (int m = 0; m < 5; m++) q_exp.push_back('{r + 3 + 4 * m, 3 + m, 0});
    @(negedge clk);
    btn_pause = 1'b0;
    check("resume_state", int'(state), 1);

    // Clear and pause together at count=7, in the cycle a tick would have fired.
    wait_until(r + 22);
    check("pre_clear_count", int'(count), 7);
    btn_clear = 1'b1;
    btn_pause = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    btn_pause = 1'b0;
    check("clear_state", int'(state), 0);
    check("clear_count", int'(count), 0);
    repeat (10) @(negedge clk);
    check("idle_state", int'(state), 0);
    check("idle_count", int'(count), 0);

    // Restart (prescaler from 0), run to 13, then pause and watch the display scan.
    q = cyc;
    btn_pause = 1'b1;
    for (int n = 0; n < 13; n++) q_exp.push_back('{q + 5 + 4 * n, n + 1, 0});
    @(negedge clk);
    btn_pause = 1'b0;
    wait_until(q + 54);
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    check("hold13_state", int'(state), 2);
    check("hold13_count", int'(count), 13);
    repeat (2) @(negedge clk);
    run      = 0;
    prev_sel = -1;
    for (int i = 0; i < 12; i++) begin
      sel_s = digit_sel;
      check("scan_sel_valid", int'(sel_s == 2'b10 || sel_s == 2'b01), 1);
      check("scan_dval", int'(digit_val), (sel_s == 2'b10) ? 1 : 3);
      if (prev_sel == -1 || int'(sel_s) == prev_sel) begin
        run++;
      end else begin
        if (i >= run && prev_sel != -1 && i != run) check("scan_period", run, 2);
        run = 1;
      end
      prev_sel = int'(sel_s);
      @(negedge clk);
    end

    // Resume, then reset asynchronously before the next tick.
    s = cyc;
    btn_pause = 1'b1;
    @(negedge clk);
    btn_pause = 1'b0;
    check("rerun_state", int'(state), 1);
    wait_until(s + 2);
    rst = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_count", int'(count), 0);
    check("async_rst_sel", int'(digit_sel), 1);
    check("async_rst_dval", int'(digit_val), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_state", int'(state), 0);
    check("post_rst_count", int'(count), 0);
    check("scoreboard_drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
